// File: rtl/door_pkg.sv
// Purpose : shared state codes, counter widths and helpers for the door sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package door_pkg;

   // Encodings are visible on the state output, so they are fixed explicitly.
   typedef enum logic [2:0] {
      CLOSED  = 3'd0,
      OPENING = 3'd1,
      HOLD    = 3'd2,
      CLOSING = 3'd3,
      FAULT   = 3'd4
   } door_state_t;

   // Hold and motor timers share one width; 8 bits covers any practical tick budget.
   localparam int TMR_W = 8;
   localparam int REV_W = 2;

   // Prescaler width for a divider of at least 2.
   function automatic int tick_cnt_w(input int div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/door_sequencer_if.sv
// Purpose : door sensor inputs and motor/status outputs bundled as one port.
// Latency : n/a (wiring only).
// Backpressure: none; every signal is level-sampled.
// Signals : sen/se/la/lc raw door inputs; ma/mc motor drives; state, fault, rev_cnt status.
interface door_sequencer_if;
   import door_pkg::*;

   logic             sen;
   logic             se;
   logic             la;
   logic             lc;
   logic             ma;
   logic             mc;
   logic [2:0]       state;
   logic             fault;
   logic [REV_W-1:0] rev_cnt;

   // master drives the door inputs and observes the controller
   modport master (output sen, se, la, lc,
                   input  ma, mc, state, fault, rev_cnt);

   // slave is the sequencer itself
   modport slave  (input  sen, se, la, lc,
                   output ma, mc, state, fault, rev_cnt);

endinterface

// File: rtl/door_tick_gen.sv
// Purpose : free-running prescaler producing a one-cycle timing tick every TICK_DIV clocks.
// Latency : tick asserts while the count sits at TICK_DIV-1.
// Backpressure: none; runs unconditionally.
// Ports   : clk, rst (sync, active-high) in; tick out.
module door_tick_gen
   import door_pkg::*;
#(
   parameter int TICK_DIV = 10000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int             CNT_W = tick_cnt_w(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst)                cnt_q <= '0;
      else if (cnt_q == LAST) cnt_q <= '0;
      else                    cnt_q <= cnt_q + 1'b1;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/door_sequencer.sv
// Purpose : automatic-door FSM: open, hold-open, close, reverse on obstruction, latch faults.
// Latency : 1 clk from input to ma/mc (3 clk with DOOR_SYNC_EN defined).
// Backpressure: none; inputs sampled every clk.
// Ports   : clk, rst (sync, active-high); bus (door_sequencer_if.slave) carries inputs and outputs.
// Build   : define DOOR_SYNC_EN to pass sen/se/la/lc through 2-flop synchronizers.
module door_sequencer
   import door_pkg::*;
#(
   parameter int TICK_DIV      = 10000000,
   parameter int HOLD_TICKS    = 5,
   parameter int MOTOR_TIMEOUT = 8,
   parameter int MAX_REV       = 3
) (
   input  logic              clk,
   input  logic              rst,
   door_sequencer_if.slave   bus
);

   localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_TICKS);
   localparam logic [TMR_W-1:0] MOT_LIM = TMR_W'(MOTOR_TIMEOUT);

   logic sen_s, se_s, la_s, lc_s;

`ifdef DOOR_SYNC_EN
   logic [3:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {bus.sen, bus.se, bus.la, bus.lc};
         sync2_q <= sync1_q;
      end
   end

   assign {sen_s, se_s, la_s, lc_s} = sync2_q;
`else
   assign {sen_s, se_s, la_s, lc_s} = {bus.sen, bus.se, bus.la, bus.lc};
`endif

   logic tick;

   door_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   door_state_t      state_q, state_d;
   logic [TMR_W-1:0] mot_q, mot_d, hold_q, hold_d;
   logic [REV_W-1:0] rev_q, rev_d;
   logic [TMR_W-1:0] mot_inc;
   logic             mot_expire;
   logic             reopen;

   assign mot_inc    = mot_q + 1'b1;
   assign mot_expire = tick && (mot_inc == MOT_LIM);
   assign reopen     = sen_s | se_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLOSED;
         mot_q   <= '0;
         hold_q  <= '0;
         rev_q   <= '0;
      end else begin
         state_q <= state_d;
         mot_q   <= mot_d;
         hold_q  <= hold_d;
         rev_q   <= rev_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mot_d   = mot_q;
      hold_d  = hold_q;
      rev_d   = rev_q;

      case (state_q)
         CLOSED: begin
            if (sen_s) state_d = OPENING;
         end
         OPENING: begin
            if (la_s) begin
               state_d = HOLD;
               hold_d  = HOLD_LD;
            end else if (tick) begin
               mot_d = mot_inc;
               if (mot_expire) state_d = FAULT;
            end
         end
         HOLD: begin
            // a reload in the same cycle as expiry keeps the door open
            if (reopen) begin
               hold_d = HOLD_LD;
            end else if (tick) begin
               if (hold_q == '0) state_d = CLOSING;
               else              hold_d  = hold_q - 1'b1;
            end
         end
         CLOSING: begin
            if (lc_s) begin
               state_d = CLOSED;
               rev_d   = '0;
            end else if (mot_expire) begin
               state_d = FAULT;
            end else begin
               if (tick) mot_d = mot_inc;
               if (reopen) begin
                  if (int'(rev_q) + 1 == MAX_REV) begin
                     state_d = FAULT;
                  end else begin
                     if (rev_q != '1) rev_d = rev_q + 1'b1;
                     state_d = OPENING;
                  end
               end
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = FAULT;
         end
      endcase

      // both limits active is physically impossible: treat as a sensor fault
      if (state_q != FAULT && la_s && lc_s) state_d = FAULT;

      // the motor watchdog restarts on every state entry
      if (state_d != state_q) mot_d = '0;
   end

   assign bus.ma      = (state_q == OPENING);
   assign bus.mc      = (state_q == CLOSING);
   assign bus.fault   = (state_q == FAULT);
   assign bus.state   = state_q;
   assign bus.rev_cnt = rev_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Purpose : directed self-checking bench for door_sequencer with short timing parameters.
// Latency : LAT tracks the input-to-state latency of the build (1, or 3 with DOOR_SYNC_EN).
// Backpressure: n/a.
module tb_door_sequencer;

   localparam int TICK_DIV      = 4;
   localparam int HOLD_TICKS    = 3;
   localparam int MOTOR_TIMEOUT = 5;
   localparam int MAX_REV       = 2;
`ifdef DOOR_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   door_sequencer_if dif();

   door_sequencer #(
      .TICK_DIV      (TICK_DIV),
      .HOLD_TICKS    (HOLD_TICKS),
      .MOTOR_TIMEOUT (MOTOR_TIMEOUT),
      .MAX_REV       (MAX_REV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   int checks = 0;
   int errors = 0;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      dif.sen = 1'b0;
      dif.se  = 1'b0;
      dif.la  = 1'b0;
      dif.lc  = 1'b0;
      step(3);
      rst = 1'b0;
   endtask

   // returns max+1 when the state never arrives
   task automatic wait_state(input logic [2:0] tgt, input int max, output int n);
      n = 0;
      while (dif.state !== tgt && n <= max) begin
         step(1);
         n++;
      end
   endtask

   task automatic pulse_sen();
      dif.sen = 1'b1; step(1); dif.sen = 1'b0; step(LAT - 1);
   endtask

   task automatic pulse_se();
      dif.se = 1'b1; step(1); dif.se = 1'b0; step(LAT - 1);
   endtask

   task automatic pulse_la();
      dif.la = 1'b1; step(1); dif.la = 1'b0; step(LAT - 1);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 5;
      if (dif.state !== 3'd0)   begin errors++; $display("FAIL reset_state: got %0d want 0", dif.state); end
      if (dif.ma !== 1'b0)      begin errors++; $display("FAIL reset_ma: got %b want 0", dif.ma); end
      if (dif.mc !== 1'b0)      begin errors++; $display("FAIL reset_mc: got %b want 0", dif.mc); end
      if (dif.fault !== 1'b0)   begin errors++; $display("FAIL reset_fault: got %b want 0", dif.fault); end
      if (dif.rev_cnt !== 2'd0) begin errors++; $display("FAIL reset_rev: got %0d want 0", dif.rev_cnt); end
   endtask

   task automatic test_normal_cycle();
      int n;
      do_reset();
      pulse_sen();
      checks += 3;
      if (dif.state !== 3'd1) begin errors++; $display("FAIL normal_opening: got %0d want 1", dif.state); end
      if (dif.ma !== 1'b1)    begin errors++; $display("FAIL normal_ma: got %b want 1", dif.ma); end
      if (dif.mc !== 1'b0)    begin errors++; $display("FAIL normal_mc_off: got %b want 0", dif.mc); end
      pulse_la();
      checks++;
      if (dif.state !== 3'd2) begin errors++; $display("FAIL normal_hold: got %0d want 2", dif.state); end
      // hold of 3 ticks expires on the 4th tick after load: 13..16 cycles
      wait_state(3'd3, 30, n);
      checks += 2;
      if (n < 13 || n > 16)   begin errors++; $display("FAIL normal_hold_time: got %0d cycles want 13..16", n); end
      if (dif.mc !== 1'b1)    begin errors++; $display("FAIL normal_mc: got %b want 1", dif.mc); end
      dif.lc = 1'b1; step(1); dif.lc = 1'b0; step(LAT - 1);
      checks += 3;
      if (dif.state !== 3'd0) begin errors++; $display("FAIL normal_closed: got %0d want 0", dif.state); end
      if (dif.ma !== 1'b0)    begin errors++; $display("FAIL normal_closed_ma: got %b want 0", dif.ma); end
      if (dif.mc !== 1'b0)    begin errors++; $display("FAIL normal_closed_mc: got %b want 0", dif.mc); end
   endtask

   task automatic test_hold_reload();
      int n;
      do_reset();
      pulse_sen();
      pulse_la();
      for (int i = 0; i < 5; i++) begin
         step(7);
         dif.sen = 1'b1; step(1); dif.sen = 1'b0;
         checks++;
         if (dif.state !== 3'd2) begin errors++; $display("FAIL reload_stay[%0d]: got %0d want 2", i, dif.state); end
      end
      wait_state(3'd3, 30, n);
      checks++;
      if (n < 12 + LAT || n > 15 + LAT) begin
         errors++; $display("FAIL reload_expiry: got %0d cycles want %0d..%0d", n, 12 + LAT, 15 + LAT);
      end
   endtask

   task automatic test_reversal();
      int n;
      do_reset();
      pulse_sen();
      pulse_la();
      wait_state(3'd3, 30, n);
      pulse_se();
      checks += 2;
      if (dif.state !== 3'd1)   begin errors++; $display("FAIL rev_reopen: got %0d want 1", dif.state); end
      if (dif.rev_cnt !== 2'd1) begin errors++; $display("FAIL rev_cnt1: got %0d want 1", dif.rev_cnt); end
      pulse_la();
      wait_state(3'd3, 30, n);
      checks++;
      if (dif.rev_cnt !== 2'd1) begin errors++; $display("FAIL rev_kept: got %0d want 1", dif.rev_cnt); end
      pulse_se();
      checks += 4;
      if (dif.state !== 3'd4) begin errors++; $display("FAIL rev_limit_state: got %0d want 4", dif.state); end
      if (dif.fault !== 1'b1) begin errors++; $display("FAIL rev_limit_fault: got %b want 1", dif.fault); end
      if (dif.ma !== 1'b0)    begin errors++; $display("FAIL rev_limit_ma: got %b want 0", dif.ma); end
      if (dif.mc !== 1'b0)    begin errors++; $display("FAIL rev_limit_mc: got %b want 0", dif.mc); end

      // closed limit beats a same-cycle obstruction and clears the count
      do_reset();
      pulse_sen();
      pulse_la();
      wait_state(3'd3, 30, n);
      pulse_se();
      pulse_la();
      wait_state(3'd3, 30, n);
      dif.lc = 1'b1; dif.se = 1'b1; step(1); dif.lc = 1'b0; dif.se = 1'b0; step(LAT - 1);
      checks += 2;
      if (dif.state !== 3'd0)   begin errors++; $display("FAIL lc_wins_state: got %0d want 0", dif.state); end
      if (dif.rev_cnt !== 2'd0) begin errors++; $display("FAIL lc_wins_rev: got %0d want 0", dif.rev_cnt); end
   endtask

   task automatic test_motor_timeout();
      int n;
      do_reset();
      pulse_sen();
      // 5 ticks after entry with the first tick 1..4 cycles away: 17..20 cycles
      wait_state(3'd4, 40, n);
      checks++;
      if (n < 17 || n > 20) begin errors++; $display("FAIL timeout_time: got %0d cycles want 17..20", n); end
      step(10);
      checks += 2;
      if (dif.state !== 3'd4) begin errors++; $display("FAIL timeout_latched: got %0d want 4", dif.state); end
      if (dif.fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b want 1", dif.fault); end
      rst = 1'b1; step(1); rst = 1'b0;
      checks += 2;
      if (dif.state !== 3'd0) begin errors++; $display("FAIL timeout_rst_state: got %0d want 0", dif.state); end
      if (dif.fault !== 1'b0) begin errors++; $display("FAIL timeout_rst_fault: got %b want 0", dif.fault); end
   endtask

   task automatic test_sensor_conflict();
      do_reset();
      dif.la = 1'b1; dif.lc = 1'b1; step(LAT);
      checks++;
      if (dif.state !== 3'd4) begin errors++; $display("FAIL conflict_fault: got %0d want 4", dif.state); end
      dif.la = 1'b0; dif.lc = 1'b0;
      do_reset();
      pulse_sen();
      checks++;
      if (dif.ma !== 1'b1) begin errors++; $display("FAIL midrst_ma_before: got %b want 1", dif.ma); end
      rst = 1'b1; step(1); rst = 1'b0;
      checks += 2;
      if (dif.ma !== 1'b0)    begin errors++; $display("FAIL midrst_ma: got %b want 0", dif.ma); end
      if (dif.state !== 3'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", dif.state); end
   endtask

`ifdef DOOR_SYNC_EN
   task automatic test_sync_latency();
      do_reset();
      dif.sen = 1'b1;
      step(2);
      checks++;
      if (dif.ma !== 1'b0) begin errors++; $display("FAIL sync_early: got %b want 0", dif.ma); end
      step(1);
      dif.sen = 1'b0;
      checks++;
      if (dif.ma !== 1'b1) begin errors++; $display("FAIL sync_lat3: got %b want 1", dif.ma); end
   endtask
`endif

   initial begin
      test_reset();
      test_normal_cycle();
      test_hold_reload();
      test_reversal();
      test_motor_timeout();
      test_sensor_conflict();
`ifdef DOOR_SYNC_EN
      test_sync_latency();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
